// File: rtl/perm_round_seq.sv
// perm_round_seq: seed/round sequencer and ARX mixing datapath for the
// 256-bit permutation state register. Runs one SEED cycle and NROUNDS
// mixing rounds per accepted start, then pulses done for one cycle.
// Optional feature macro: PRS_ABORT_EN (adds the abort input).
module perm_round_seq #(
  parameter int unsigned NROUNDS = 12
) (
  input  logic         clk,
  input  logic         reset,
`ifdef PRS_ABORT_EN
  input  logic         abort,
`endif
  input  logic         start,
  input  logic [255:0] msg,
  input  logic [255:0] state_q,
  output logic [255:0] state_d,
  output logic         state_en,
  output logic         state_clear,
  output logic         busy,
  output logic         done,
  output logic [7:0]   round
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [7:0]  LAST_ROUND = 8'(NROUNDS - 1);
  localparam logic [31:0] RC_BASE    = 32'h9E3779B9;
  localparam int unsigned ROT [8]    = '{7, 9, 13, 18, 7, 9, 13, 18};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_round;
  logic [7:0]     w_round_nxt;
  logic [255:0]   r_msg;
  logic [255:0]   w_mix;
  logic           w_abort;

`ifdef PRS_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // ARX round function of the current feedback word set and round index
  always_comb begin
    logic [31:0] w_sum;
    w_mix = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_sum = state_q[32*i +: 32] + state_q[32*((i + 1) % 8) +: 32];
      w_mix[32*i +: 32] = rotl32(w_sum, ROT[i]);
    end
    w_mix[31:0] = w_mix[31:0] ^ RC_BASE ^ {24'h0, r_round};
  end

  // State register and round counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Message capture on the start acceptance edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_msg <= msg;
    end
  end

  // Next-state and output decode from state and round counter
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    state_d     = '0;
    state_en    = 1'b0;
    state_clear = 1'b0;
    done        = 1'b0;
    busy        = (r_state != ST_IDLE);
    round       = r_round;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SEED;
      end
      ST_SEED: begin
        state_en    = 1'b1;
        state_clear = 1'b1;
        state_d     = r_msg;
        w_round_nxt = '0;
        w_state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        state_en = 1'b1;
        state_d  = w_mix;
        // counter holds at the last index so it never exceeds NROUNDS-1
        if (r_round == LAST_ROUND) w_state_nxt = ST_DONE;
        else                       w_round_nxt = r_round + 8'd1;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      state_en    = 1'b0;
      done        = 1'b0;
    end
  end

endmodule

// File: tb/tb_perm_round_seq.sv
// Scoreboard bench for perm_round_seq with a behavioural state register,
// a timeline model of each run and a word-level reference of the mix rounds.
module tb_perm_round_seq;

  localparam int unsigned NR = 12;
  localparam logic [255:0] SEED = {16'hFFFF, 240'h0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] msg = '0;
  logic [255:0] state_q = '0;
  logic [255:0] state_d;
  logic         state_en, state_clear, busy, done;
  logic [7:0]   round;

  int unsigned  n_tests = 0;
  int unsigned  n_fail = 0;
  int unsigned  n_done = 0;

  logic [255:0] exp_q [$];
  bit           m_busy = 1'b0;
  int unsigned  m_cnt = 0;
  logic [255:0] m_msg = '0;

  perm_round_seq #(.NROUNDS(NR)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef PRS_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .msg         (msg),
    .state_q     (state_q),
    .state_d     (state_d),
    .state_en    (state_en),
    .state_clear (state_clear),
    .busy        (busy),
    .done        (done),
    .round       (round)
  );

  always #5 clk = ~clk;

  // downstream permutation state register (not reset by the sequencer)
  always @(posedge clk)
    if (state_en) state_q <= state_d ^ (state_clear ? SEED : 256'h0);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_round(input logic [255:0] s, input int unsigned r);
    logic [31:0] w [8];
    logic [31:0] o [8];
    logic [31:0] t;
    int unsigned rot [8];
    logic [255:0] res;
    rot = '{7, 9, 13, 18, 7, 9, 13, 18};
    for (int i = 0; i < 8; i++) w[i] = s[32*i +: 32];
    for (int i = 0; i < 8; i++) begin
      t = w[i] + w[(i + 1) % 8];
      o[i] = (t << rot[i]) | (t >> (32 - rot[i]));
    end
    o[0] = o[0] ^ 32'h9E3779B9 ^ 32'(r);
    for (int i = 0; i < 8; i++) res[32*i +: 32] = o[i];
    return res;
  endfunction

  function automatic logic [255:0] ref_run(input logic [255:0] m);
    logic [255:0] s;
    s = SEED ^ m;
    for (int unsigned r = 0; r < NR; r++) s = ref_round(s, r);
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // timeline model: acceptance only when idle, run lasts NR+2 cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 1'b0;
        void'(exp_q.pop_back());
      end else begin
        m_cnt++;
        if (m_cnt == NR + 2) m_busy = 1'b0;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_msg  = msg;
      exp_q.push_back(ref_run(msg));
    end
  end

  // monitor: per-cycle output check against the timeline, final state on done
  always @(negedge clk) begin
    bit           e_en, e_clr, e_done;
    logic [255:0] e_d;
    e_en = 1'b0; e_clr = 1'b0; e_done = 1'b0; e_d = '0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        e_en = 1'b1; e_clr = 1'b1; e_d = m_msg;
      end else if (m_cnt <= NR) begin
        e_en = 1'b1;
        e_d  = ref_round(state_q, m_cnt - 1);
        chk("round_idx", {248'h0, round}, 256'(m_cnt - 1));
      end else begin
        e_done = 1'b1;
        chk("round_last", {248'h0, round}, 256'(NR - 1));
      end
      if (m_msg == '0 && m_cnt == 1) chk("seed_q", state_q, SEED);
      if (m_msg == '0 && m_cnt == 2) begin
        chk("r0_w7", {224'h0, state_q[255:224]}, 256'h0003FFFC);
        chk("r0_w6", {224'h0, state_q[223:192]}, 256'hE0001FFF);
        chk("r0_w0", {224'h0, state_q[31:0]}, 256'h9E3779B9);
        chk("r0_mid", {64'h0, state_q[191:32]}, 256'h0);
      end
    end
    chk("busy", {255'h0, busy}, {255'h0, m_busy});
    chk("state_en", {255'h0, state_en}, {255'h0, e_en});
    chk("state_clear", {255'h0, state_clear}, {255'h0, e_clr});
    chk("done", {255'h0, done}, {255'h0, e_done});
    chk("state_d", state_d, e_d);
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got done=1 required no pending run");
      end else begin
        chk("final_q", state_q, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int unsigned c = 0;
    while ((busy || m_busy) && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (c >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got busy=%0b required 0 within 400 cycles", busy);
    end
  endtask

  task automatic wait_round(input logic [7:0] v);
    int unsigned c = 0;
    while (!(busy && state_en && !state_clear && round == v) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL round_timeout: got round=%0d required %0d", round, v);
    end
  endtask

  task automatic pulse_start(input logic [255:0] m);
    @(negedge clk);
    msg = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int unsigned d0;
    logic [255:0] hold;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {255'h0, busy}, 256'h0);
    chk("rst_en", {255'h0, state_en}, 256'h0);
    chk("rst_clear", {255'h0, state_clear}, 256'h0);
    chk("rst_done", {255'h0, done}, 256'h0);
    chk("rst_round", {248'h0, round}, 256'h0);
    chk("rst_d", state_d, 256'h0);
    reset = 1'b0;

    // zero message: known first-round constants
    pulse_start('0);
    wait_idle();

    // random runs with spurious start activity while busy
    for (int k = 0; k < 6; k++) begin
      pulse_start(rand256());
      while (busy) begin
        start = 1'($urandom_range(0, 1));
        msg = rand256();
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
    end

    // start held high: back-to-back runs every NR+3 cycles
    d0 = n_done;
    @(negedge clk);
    msg = rand256(); start = 1'b1;
    repeat (3 * (NR + 3)) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("held_runs", 256'(n_done - d0), 256'd3);

    // asynchronous reset in the middle of a run
    pulse_start(rand256());
    wait_round(8'd5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {255'h0, busy}, 256'h0);
    chk("mid_rst_en", {255'h0, state_en}, 256'h0);
    chk("mid_rst_round", {248'h0, round}, 256'h0);
    chk("mid_rst_d", state_d, 256'h0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start(rand256());
    wait_idle();

`ifdef PRS_ABORT_EN
    d0 = n_done;
    pulse_start(rand256());
    wait_round(8'd3);
    #2 abort = 1'b1;
    #1;
    chk("abort_en", {255'h0, state_en}, 256'h0);
    chk("abort_done", {255'h0, done}, 256'h0);
    hold = state_q;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {255'h0, busy}, 256'h0);
    chk("abort_hold", state_q, hold);
    wait_idle();
    chk("abort_no_done", 256'(n_done - d0), 256'd0);
`else
    hold = '0;
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", 256'(exp_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/perm_round_seq.md
# perm_round_seq

Round sequencer and mixing datapath that drives the 256-bit permutation state register. It sits directly upstream of that register: it produces the register's `d`, `en` and `clear` inputs and reads its `q` back as feedback. Per accepted `start`, it runs one seed cycle and then `NROUNDS` ARX mixing rounds, then pulses `done`. The register XORs its seed constant, 256'hFFFF followed by 240 zero bits, into `d` on `clear`.

## Interface
- `NROUNDS`, default 12: rounds per run; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `start` input 1: run request; sampled only in IDLE.
- `msg` input 256: block to absorb; captured on the `start` acceptance edge.
- `state_q` input 256: feedback from the downstream state register.
- `state_d` output 256: next-state data to the register.
- `state_en` output 1: register enable.
- `state_clear` output 1: register seed-XOR select.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: single-cycle completion pulse.
- `round` output 8: current round index.
- `abort` input 1: present only with `PRS_ABORT_EN`.

## Operation
- FSM states: IDLE, SEED, ROUND, DONE. The state register and the round counter are flops; all outputs decode from them.
- Word view: w_i = bits [32i+31:32i], i=0..7.
- IDLE:
  - `start`=1 latches `msg` into `msg_q` and moves to SEED.
  - Outputs: `state_en`=0, `state_clear`=0, `state_d`=0.
- SEED, one cycle:
  - `state_en`=1, `state_clear`=1, `state_d`=`msg_q`.
  - `round` is cleared to 0; next state is ROUND.
- ROUND:
  - `state_en`=1, `state_clear`=0, `state_d`=f(`state_q`, `round`).
  - `round` increments each cycle.
  - After the cycle with `round`=NROUNDS-1, move to DONE.
- Round function f, for each i:
  - w_i' = rotl32((w_i + w_(i+1 mod 8)) mod 2^32, R_i) XOR (i==0 ? rc : 0).
  - R = {7,9,13,18,7,9,13,18} for i=0..7.
  - rc = 32'h9E3779B9 XOR {24'h0, round}.
- DONE, one cycle: `done`=1, `state_en`=0; next state is IDLE. The result is `state_q` as seen during DONE.
- `start` outside IDLE is ignored. `start` in the DONE cycle is also ignored; it must be re-asserted in IDLE.
- Reset mid-run:
  - The FSM goes to IDLE and `round`, `msg_q` and all outputs clear to 0.
  - The downstream register is not reset by this block.

## Timing
- Reset values: `state_d`=0, `state_en`=0, `state_clear`=0, `busy`=0, `done`=0, `round`=0.
- For `start` accepted at edge k:
  - SEED occupies cycle k+1.
  - Rounds occupy cycles k+2 .. k+1+NROUNDS.
  - DONE occupies cycle k+2+NROUNDS.
  - The earliest next acceptance is the edge ending cycle k+3+NROUNDS.
- Throughput: one run per NROUNDS+3 cycles.
- `busy` rises at edge k and falls at the edge ending DONE.
- f is purely combinational from `state_q` within a cycle; there is no extra pipeline stage.

## Configuration
- `PRS_ABORT_EN` defined:
  - Adds the `abort` port.
  - `abort`=1 in SEED, ROUND or DONE forces IDLE at the next edge.
  - `state_en` is forced to 0 in that same cycle, and `done` is suppressed.
  - `abort` has priority over `start` and over normal transitions.
- `PRS_ABORT_EN` undefined: no `abort` port; a run always completes.

## Test plan
- Reset mid-ROUND (`round`=5, NROUNDS=12): all outputs go to 0 immediately. A new `start` afterwards completes with `done` exactly 14 cycles after acceptance.
- NROUNDS=1, `msg`=0, with the downstream register attached:
  - SEED leaves `state_q`=256'hFFFF<<240.
  - After the round, w7=32'h0003FFFC, w6=32'hE0001FFF, w0=32'h9E3779B9, all other words 0.
  - `done` is seen at k+3.
- NROUNDS=12, `start` held high continuously: runs are accepted every 15 cycles, `done` pulses once per run, and `round` sequences 0..11.
- `start` pulsed during ROUND and during DONE: ignored. `busy` drops after DONE and there is no second run.
- `PRS_ABORT_EN`, `abort` at `round`=3: IDLE next edge, no `done`, `state_en`=0 in the abort cycle, and `state_q` holds its value.
- Random `msg`, NROUNDS=255: final `state_q` matches the reference model of f applied 255 times to (seed constant XOR `msg`); `round` never exceeds 254.
